register_read_sequencer: RTL and testbench
==========================================

REGISTER_READ_SEQUENCER -- requirements
Module: register_read_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 24, meaning register data width in bits.
REQ-002 The block SHALL have parameter NUM_REGS, default 16, meaning number of registers in the bank.
REQ-003 The block SHALL have parameter ADDR_W, default 4, meaning register address width (clog2 of NUM_REGS).
REQ-004 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port RegBank  input  NUM_REGS*N  flattened bank contents; register i at bits [i*N +: N].
REQ-007 The block SHALL have port Start  input  1  request to begin a read sequence.
REQ-008 The block SHALL have port StartAddr  input  ADDR_W  first register index to read.
REQ-009 The block SHALL have port Count  input  ADDR_W+1  number of registers to read.
REQ-010 The block SHALL have port ReadReady  input  1  consumer ready to accept the current beat.
REQ-011 The block SHALL have port ReadValid  output  1  ReadData/ReadAddr hold a valid beat.
REQ-012 The block SHALL have port ReadData  output  N  register value of the current beat.
REQ-013 The block SHALL have port ReadAddr  output  ADDR_W  register index of the current beat.
REQ-014 The block SHALL have port Busy  output  1  sequence in progress; Start ignored.
REQ-015 The block SHALL have port Done  output  1  one-cycle pulse at end of sequence.

Function
REQ-016 The block SHALL implement FSM states IDLE, READ, DONE; all outputs registered.
REQ-017 In IDLE, Start=1 with Count>0 SHALL latch StartAddr and min(Count, NUM_REGS), transitioning to READ.
REQ-018 In IDLE, Start=1 with Count=0 SHALL transition directly to DONE, producing no beats.
REQ-019 First beat SHALL be presented the cycle after Start is sampled: ReadValid=1, ReadAddr=StartAddr, ReadData=RegBank[StartAddr] as sampled on the Start edge.
REQ-020 A beat SHALL transfer on a rising edge where ReadValid=1 and ReadReady=1.
REQ-021 While ReadValid=1 and ReadReady=0, ReadData and ReadAddr SHALL hold stable, even if RegBank changes.
REQ-022 On a transfer with remaining count >1, the next beat SHALL load on the same edge: address+1, modulo NUM_REGS (index NUM_REGS-1 wraps to 0); data from RegBank sampled on that edge.
REQ-023 With ReadReady held high, throughput SHALL be one beat per cycle with no bubbles.
REQ-024 On transfer of the last beat, the FSM SHALL enter DONE: ReadValid=0, Done=1, Busy=1 for exactly one cycle, then return to IDLE.
REQ-025 Busy SHALL be 1 in READ and DONE, and 0 in IDLE.
REQ-026 Start SHALL be ignored outside IDLE; StartAddr/Count changes after latch SHALL have no effect.
REQ-027 The block SHALL never issue a beat for an index not in the latched sequence, nor repeat an index within one sequence.

Reset
REQ-028 rst=1 sampled on a rising edge SHALL force IDLE with ReadValid=0, ReadData=0, ReadAddr=0, Busy=0, Done=0, internal count=0.
REQ-029 rst SHALL take priority over Start and over any transfer in the same cycle.
REQ-030 rst asserted mid-sequence SHALL abort it with no Done pulse; the next Start begins a fresh sequence.

Verification
REQ-031 Bank reg i = 24'h11111*i; Start, StartAddr=2, Count=3, ReadReady=1 -> beats (2,22222),(3,33333),(4,44444) on consecutive cycles, then Done pulse one cycle, Busy=0 after.
REQ-032 StartAddr=14, Count=4, ReadReady=1 -> addresses 14,15,0,1 with matching data; Done once.
REQ-033 Count=3, ReadReady toggled 0,0,1,0,1,1 -> each beat held stable while not ready; exactly 3 transfers; register 3 rewritten to 24'hAAAAA while held -> held beat unchanged.
REQ-034 Count=0 -> no ReadValid; Done=1 the cycle after Start; Count=20 -> exactly 16 beats.
REQ-035 rst=1 during second beat of a Count=5 sequence -> all outputs 0 next cycle, no Done; new Start then runs normally.
REQ-036 Start pulsed while Busy=1 with different StartAddr -> ignored; original sequence completes unchanged.

Source files
------------

// File: rtl/register_read_sequencer.sv
// ----------------------------------------------------------------------------
// register_read_sequencer
//
// Walks a register bank: on Start it latches a first index and a length, then
// presents one register per beat on a valid/ready handshake. The index steps
// by one per transfer and wraps from NUM_REGS-1 back to 0. The sequence ends
// with a single Done pulse.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   rst        synchronous, active-high reset
//   RegBank    flattened bank, register i at bits [i*N +: N]
//   Start      request to begin a read sequence (honoured only while idle)
//   StartAddr  first register index to read
//   Count      number of registers to read (clamped to NUM_REGS)
//   ReadReady  consumer accepts the current beat
//   ReadValid  ReadData/ReadAddr hold a valid beat
//   ReadData   register value of the current beat
//   ReadAddr   register index of the current beat
//   Busy       sequence in progress, Start ignored
//   Done       one-cycle pulse at the end of a sequence
// ----------------------------------------------------------------------------
module register_read_sequencer #(
  parameter int N        = 24,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REGS*N-1:0] RegBank,
  input  logic                  Start,
  input  logic [ADDR_W-1:0]     StartAddr,
  input  logic [ADDR_W:0]       Count,
  input  logic                  ReadReady,
  output logic                  ReadValid,
  output logic [N-1:0]          ReadData,
  output logic [ADDR_W-1:0]     ReadAddr,
  output logic                  Busy,
  output logic                  Done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LEN_MAX  = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W:0]   remaining;   // beats left including the one on display
  logic [ADDR_W:0]   start_len;
  logic [ADDR_W-1:0] next_addr;
  logic              start_ok;
  logic              fire;
  logic              valid_d;
  logic              busy_d;
  logic              done_d;

  assign start_ok  = (state == IDLE) && Start && (Count != '0);
  // ReadValid is high exactly when the FSM sits in READ.
  assign fire      = (state == READ) && ReadReady;
  assign start_len = (Count > LEN_MAX) ? LEN_MAX : Count;
  // Explicit wrap so a non-power-of-two bank still cycles back to 0.
  assign next_addr = (ReadAddr == LAST_IDX) ? '0 : ReadAddr + ADDR_W'(1);

  // State register plus the registered status outputs.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking assignments here would create order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ReadValid <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= next_state;
      ReadValid <= valid_d;
      Busy      <= busy_d;
      Done      <= done_d;
    end
  end

  // Next-state logic.
  // NOTE: the default assignment first means every path drives next_state,
  // so no latch can be inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (Start) next_state = (Count == '0) ? DONE : READ;
      READ: if (ReadReady && remaining <= LEN_ONE) next_state = DONE;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the upcoming state, so the status flops line up with
  // the state they describe.
  always_comb begin
    valid_d = (next_state == READ);
    busy_d  = (next_state != IDLE);
    done_d  = (next_state == DONE);
  end

  // Beat datapath. The bank is sampled only when a beat is loaded, so a
  // stalled beat stays stable while the bank changes underneath it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ReadData  <= '0;
      ReadAddr  <= '0;
      remaining <= '0;
    end else if (start_ok) begin
      ReadAddr  <= StartAddr;
      ReadData  <= RegBank[int'(StartAddr)*N +: N];
      remaining <= start_len;
    end else if (fire) begin
      if (remaining > LEN_ONE) begin
        ReadAddr  <= next_addr;
        ReadData  <= RegBank[int'(next_addr)*N +: N];
        remaining <= remaining - LEN_ONE;
      end else begin
        remaining <= '0;
      end
    end
  end

endmodule

// File: tb/tb_register_read_sequencer.sv
// ----------------------------------------------------------------------------
// Testbench for register_read_sequencer. The reference model is a queue of
// expected register indices built from the start index and clamped length;
// each beat's data is the bank value the bench captured at the edge on which
// that beat was loaded (the Start edge or the previous transfer).
// ----------------------------------------------------------------------------
module tb_register_read_sequencer;

  localparam int N        = 24;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int MAX_CYC  = 200;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REGS*N-1:0] RegBank;
  logic                  Start;
  logic [ADDR_W-1:0]     StartAddr;
  logic [ADDR_W:0]       Count;
  logic                  ReadReady;
  logic                  ReadValid;
  logic [N-1:0]          ReadData;
  logic [ADDR_W-1:0]     ReadAddr;
  logic                  Busy;
  logic                  Done;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_pat[$];

  register_read_sequencer #(
    .N(N), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .RegBank(RegBank), .Start(Start),
    .StartAddr(StartAddr), .Count(Count), .ReadReady(ReadReady),
    .ReadValid(ReadValid), .ReadData(ReadData), .ReadAddr(ReadAddr),
    .Busy(Busy), .Done(Done)
  );

  always #5 clk = ~clk;

  task automatic load_default_bank();
    for (int i = 0; i < NUM_REGS; i++) RegBank[i*N +: N] = N'(32'h11111 * i);
  endtask

  // Runs one complete sequence and checks every cycle against the model.
  task automatic run_seq(input string name, input int sa, input int cnt,
                         input bit rand_ready, input bit mutate,
                         input bit poke, input int rewrite_cyc);
    int                    addrs[$];
    int                    len;
    int                    cyc;
    int                    xfers;
    logic [N-1:0]          exp_data;
    logic [NUM_REGS*N-1:0] snap;
    len = (cnt > NUM_REGS) ? NUM_REGS : cnt;
    for (int k = 0; k < len; k++) addrs.push_back((sa + k) % NUM_REGS);
    exp_data = '0;
    xfers    = 0;

    Start = 1'b1; StartAddr = ADDR_W'(sa); Count = (ADDR_W+1)'(cnt);
    snap = RegBank;
    @(posedge clk); #1;
    Start = 1'b0;
    StartAddr = ADDR_W'($urandom); Count = (ADDR_W+1)'($urandom);
    if (len > 0) exp_data = snap[addrs[0]*N +: N];

    cyc = 0;
    forever begin
      if (addrs.size() == 0) begin
        n_checks++;
        if ({ReadValid, Busy, Done} !== 3'b011) begin
          n_fail++;
          $display("FAIL %s done_state: valid/busy/done=%b expected 011 (xfers=%0d)",
                   name, {ReadValid, Busy, Done}, xfers);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({ReadValid, Busy, Done} !== 3'b000) begin
          n_fail++;
          $display("FAIL %s idle_after_done: valid/busy/done=%b expected 000",
                   name, {ReadValid, Busy, Done});
        end
        break;
      end
      n_checks++;
      if ({ReadValid, Busy, Done} !== 3'b110 || ReadAddr !== ADDR_W'(addrs[0])
          || ReadData !== exp_data) begin
        n_fail++;
        $display("FAIL %s beat%0d: vbd=%b addr=%0d data=%h expected vbd=110 addr=%0d data=%h",
                 name, xfers, {ReadValid, Busy, Done}, ReadAddr, ReadData,
                 addrs[0], exp_data);
      end
      if (cyc >= MAX_CYC) begin
        n_checks++; n_fail++;
        $display("FAIL %s timeout: %0d beats left after %0d cycles", name,
                 addrs.size(), cyc);
        break;
      end
      if (ready_pat.size() > 0) ReadReady = ready_pat.pop_front() != 0;
      else ReadReady = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (mutate) RegBank[$urandom_range(0, NUM_REGS-1)*N +: N] = N'($urandom);
      if (cyc == rewrite_cyc) RegBank[3*N +: N] = 24'hAAAAA;
      if (poke && cyc == 1) begin
        Start = 1'b1; StartAddr = ADDR_W'((sa + 7) % NUM_REGS); Count = 5'd2;
      end
      snap = RegBank;
      @(posedge clk); #1;
      Start = 1'b0;
      if (ReadReady) begin
        void'(addrs.pop_front());
        xfers++;
        if (addrs.size() > 0) exp_data = snap[addrs[0]*N +: N];
      end
      cyc++;
    end
    ReadReady = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; Start = 1'b1; StartAddr = 4'd5; Count = 5'd3; ReadReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({ReadValid, Busy, Done} !== 3'b000 || ReadAddr !== '0 || ReadData !== '0) begin
      n_fail++;
      $display("FAIL reset_state: vbd=%b addr=%0d data=%h expected all zero",
               {ReadValid, Busy, Done}, ReadAddr, ReadData);
    end
    rst = 1'b0; Start = 1'b0; ReadReady = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ReadValid, Busy, Done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_release_idle: vbd=%b expected 000", {ReadValid, Busy, Done});
    end
  endtask

  task automatic test_basic();
    load_default_bank();
    run_seq("basic", 2, 3, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_wrap();
    load_default_bank();
    run_seq("wrap", 14, 4, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    load_default_bank();
    ready_pat = '{0, 0, 1, 0, 1, 1};
    run_seq("backpressure", 2, 3, 1'b0, 1'b0, 1'b0, 3);
  endtask

  task automatic test_zero_and_clamp();
    load_default_bank();
    run_seq("count_zero", 9, 0, 1'b0, 1'b0, 1'b0, -1);
    run_seq("count_clamp", 5, 20, 1'b0, 1'b0, 1'b0, -1);
    run_seq("count_full", 15, 16, 1'b1, 1'b0, 1'b0, -1);
  endtask

  task automatic test_reset_mid();
    load_default_bank();
    Start = 1'b1; StartAddr = 4'd0; Count = 5'd5;
    @(posedge clk); #1;
    Start = 1'b0; ReadReady = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ReadValid !== 1'b1 || ReadAddr !== 4'd1 || ReadData !== 24'h11111) begin
      n_fail++;
      $display("FAIL reset_mid_beat2: valid=%b addr=%0d data=%h expected 1 1 11111",
               ReadValid, ReadAddr, ReadData);
    end
    rst = 1'b1; Start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; Start = 1'b0; ReadReady = 1'b0;
    n_checks++;
    if ({ReadValid, Busy, Done} !== 3'b000 || ReadAddr !== '0 || ReadData !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: vbd=%b addr=%0d data=%h expected all zero",
               {ReadValid, Busy, Done}, ReadAddr, ReadData);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({ReadValid, Busy, Done} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_mid_no_done: cycle %0d vbd=%b expected 000", i,
                 {ReadValid, Busy, Done});
      end
    end
    run_seq("after_reset", 6, 3, 1'b0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_start_ignored();
    load_default_bank();
    run_seq("start_ignored", 4, 6, 1'b0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NUM_REGS; i++) RegBank[i*N +: N] = N'($urandom);
      run_seq($sformatf("random%0d", t), $urandom_range(0, NUM_REGS-1),
              $urandom_range(0, 31), 1'b1, 1'b1, ($urandom_range(0, 1) == 1), -1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; Start = 1'b0; StartAddr = '0; Count = '0; ReadReady = 1'b0;
    RegBank = '0;
    #1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_and_clamp();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
